dp_sequencer: RTL

//  Moore controller that sequences the register-file/ALU datapath for one instruction per start pulse.

---
 rtl/dp_sequencer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dp_sequencer.sv
// -----------------------------------------------------------------------------
// dp_sequencer
//
// Moore controller that steps the register-file / ALU datapath through one
// instruction per accepted start pulse. On an accepted start the {opcode, op}
// pair is latched, and the controller walks DECODE and then GET_A / GET_B /
// ALU / WR_RD / WR_IMM as the instruction requires. All outputs come from
// flops and depend only on the current state and the latched instruction.
// There is no combinational path from s, opcode or op to any output.
//
// Parameters
//   CNT_W         width of the retired-instruction counter
//   ILLEGAL_HALT  1: an illegal opcode parks in HALT until reset
//                 0: an illegal opcode returns to WAIT
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous reset, active low
//   s        start; sampled only while w = 1
//   opcode   instr[15:13] from the decoder
//   op       instr[12:11] from the decoder
//   nsel     one-hot register select (001 Rn, 010 Rd, 100 Rm, 000 none)
//   vsel     writeback source (00 C, 10 sximm8)
//   write    register-file write enable
//   loada / loadb / loadc / loads
//            datapath register load strobes
//   asel     forces ALU input A to zero
//   bsel     selects sximm5 for ALU input B (never asserted here)
//   w        idle, ready for s
//   done     high in the last state of a legal instruction
//   err      sticky illegal-instruction flag, cleared by the next accept
//   retired  count of completed legal instructions (wraps)
//
// Optional trace (define DP_SEQ_TRACE_EN)
//   last_state  encoded state held before the most recent state change
//   cyc         cycles spent outside WAIT by the current/last instruction
// -----------------------------------------------------------------------------
module dp_sequencer #(
    parameter int CNT_W        = 16,
    parameter int ILLEGAL_HALT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [2:0]       opcode,
    input  logic [1:0]       op,
    output logic [2:0]       nsel,
    output logic [1:0]       vsel,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic             w,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] retired
`ifdef DP_SEQ_TRACE_EN
    ,
    output logic [2:0]       last_state,
    output logic [3:0]       cyc
`endif
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_ALU    = 3'd4,
        S_WR_RD  = 3'd5,
        S_WR_IMM = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    // Datapath strobes, registered together so every output is a flop.
    typedef struct packed {
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       w;
        logic       done;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        nsel: 3'b000, vsel: 2'b00, write: 1'b0, loada: 1'b0, loadb: 1'b0,
        loadc: 1'b0, loads: 1'b0, asel: 1'b0, bsel: 1'b0, w: 1'b1, done: 1'b0
    };

    // {opcode, op} encodings of the legal instructions
    localparam logic [4:0] I_MOV_IMM = 5'b110_10;
    localparam logic [4:0] I_MOV_REG = 5'b110_00;
    localparam logic [4:0] I_ADD     = 5'b101_00;
    localparam logic [4:0] I_CMP     = 5'b101_01;
    localparam logic [4:0] I_AND     = 5'b101_10;
    localparam logic [4:0] I_MVN     = 5'b101_11;

    state_t           state_q,   state_d;
    logic [4:0]       instr_q,   instr_d;
    logic             err_q,     err_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    ctrl_t            ctrl_q,    ctrl_d;
`ifdef DP_SEQ_TRACE_EN
    logic [2:0]       last_state_q, last_state_d;
    logic [3:0]       cyc_q,        cyc_d;
`endif

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        err_d     = err_q;
        retired_d = retired_q;

        // done_q marks the final state; the instruction retires as we leave it.
        if (ctrl_q.done) begin
            retired_d = retired_q + CNT_W'(1);
        end

        unique case (state_q)
            S_WAIT: begin
                if (s) begin
                    instr_d = {opcode, op};
                    err_d   = 1'b0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (instr_q)
                    I_MOV_IMM:              state_d = S_WR_IMM;
                    I_MOV_REG, I_MVN:       state_d = S_GET_B;
                    I_ADD, I_AND, I_CMP:    state_d = S_GET_A;
                    default: begin
                        err_d   = 1'b1;
                        state_d = (ILLEGAL_HALT != 0) ? S_HALT : S_WAIT;
                    end
                endcase
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_ALU;
            // CMP only updates status, so it finishes in ALU.
            S_ALU:    state_d = (instr_q == I_CMP) ? S_WAIT : S_WR_RD;
            S_WR_RD:  state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_WAIT;
        endcase

        // Strobes are decoded from the state being entered and then registered,
        // so they line up with state_q on the following cycle.
        ctrl_d = '0;
        unique case (state_d)
            S_WAIT: ctrl_d.w = 1'b1;
            S_GET_A: begin
                ctrl_d.nsel  = 3'b001;
                ctrl_d.loada = 1'b1;
            end
            S_GET_B: begin
                ctrl_d.nsel  = 3'b100;
                ctrl_d.loadb = 1'b1;
            end
            S_ALU: begin
                ctrl_d.loadc = 1'b1;
                ctrl_d.loads = (instr_d == I_CMP);
                ctrl_d.done  = (instr_d == I_CMP);
                // MOV Rd,Rm and MVN pass only operand B through the ALU.
                ctrl_d.asel  = (instr_d == I_MOV_REG) || (instr_d == I_MVN);
            end
            S_WR_RD: begin
                ctrl_d.nsel  = 3'b010;
                ctrl_d.vsel  = 2'b00;
                ctrl_d.write = 1'b1;
                ctrl_d.done  = 1'b1;
            end
            S_WR_IMM: begin
                ctrl_d.nsel  = 3'b001;
                ctrl_d.vsel  = 2'b10;
                ctrl_d.write = 1'b1;
                ctrl_d.done  = 1'b1;
            end
            default: ctrl_d = '0;   // DECODE and HALT drive nothing
        endcase

`ifdef DP_SEQ_TRACE_EN
        last_state_d = last_state_q;
        if (state_d != state_q) begin
            last_state_d = state_q;
        end
        cyc_d = cyc_q;
        if (state_q == S_WAIT) begin
            if (s) begin
                cyc_d = 4'd0;
            end
        end else begin
            cyc_d = cyc_q + 4'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_WAIT;
            instr_q   <= '0;
            err_q     <= 1'b0;
            retired_q <= '0;
            ctrl_q    <= CTRL_IDLE;
`ifdef DP_SEQ_TRACE_EN
            last_state_q <= '0;
            cyc_q        <= '0;
`endif
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            err_q     <= err_d;
            retired_q <= retired_d;
            ctrl_q    <= ctrl_d;
`ifdef DP_SEQ_TRACE_EN
            last_state_q <= last_state_d;
            cyc_q        <= cyc_d;
`endif
        end
    end

    assign nsel    = ctrl_q.nsel;
    assign vsel    = ctrl_q.vsel;
    assign write   = ctrl_q.write;
    assign loada   = ctrl_q.loada;
    assign loadb   = ctrl_q.loadb;
    assign loadc   = ctrl_q.loadc;
    assign loads   = ctrl_q.loads;
    assign asel    = ctrl_q.asel;
    assign bsel    = ctrl_q.bsel;
    assign w       = ctrl_q.w;
    assign done    = ctrl_q.done;
    assign err     = err_q;
    assign retired = retired_q;
`ifdef DP_SEQ_TRACE_EN
    assign last_state = last_state_q;
    assign cyc        = cyc_q;
`endif

endmodule
